// File: rtl/matrix_store_writer.sv
// Matrix store initiator: allocates a directory slot, streams elements
// into BRAM, then commits the slot metadata. One matrix in flight.
module matrix_store_writer #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 12,
    parameter int MAX_DIM       = 5,
    parameter int ALLOC_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [3:0]               start_m,
    input  logic [3:0]               start_n,
    input  logic                     abort,
    input  logic                     elem_valid,
    input  logic [ELEMENT_WIDTH-1:0] elem_data,
    output logic                     elem_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               err_code,
    output logic [3:0]               result_slot,
    output logic                     alloc_req,
    output logic [3:0]               alloc_m,
    output logic [3:0]               alloc_n,
    input  logic                     alloc_valid,
    input  logic [3:0]               alloc_slot,
    input  logic [ADDR_WIDTH-1:0]    alloc_addr,
    output logic                     commit_req,
    output logic [3:0]               commit_slot,
    output logic [3:0]               commit_m,
    output logic [3:0]               commit_n,
    output logic [ADDR_WIDTH-1:0]    commit_addr,
    output logic                     bram_we,
    output logic [ADDR_WIDTH-1:0]    bram_addr,
    output logic [ELEMENT_WIDTH-1:0] bram_din
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ALLOC  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam int TW = (ALLOC_TIMEOUT > 1) ? $clog2(ALLOC_TIMEOUT) : 1;

    localparam logic [1:0] E_DIMS  = 2'b01;
    localparam logic [1:0] E_SPACE = 2'b10;
    localparam logic [1:0] E_ABORT = 2'b11;

    logic [2:0]            state_q, state_d;
    logic [3:0]            m_q, m_d;
    logic [3:0]            n_q, n_d;
    logic [7:0]            total_q, total_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [3:0]            slot_q, slot_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic [3:0]            res_q, res_d;

    logic dims_ok;
    logic hs;

    assign dims_ok = (start_m != 4'd0) && (start_m <= 4'(MAX_DIM))
                  && (start_n != 4'd0) && (start_n <= 4'(MAX_DIM));
    assign hs      = (state_q == S_WRITE) && elem_valid;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        slot_d  = slot_q;
        base_d  = base_q;
        err_d   = 1'b0;
        code_d  = code_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start && dims_ok) begin
                    m_d     = start_m;
                    n_d     = start_n;
                    total_d = {4'd0, start_m} * {4'd0, start_n};
                    code_d  = 2'b00;
                    state_d = S_ALLOC;
                end else if (start) begin
                    err_d  = 1'b1;
                    code_d = E_DIMS;
                end
            end
            S_ALLOC: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    err_d   = 1'b1;
                    code_d  = E_ABORT;
                    state_d = S_IDLE;
                end else if (alloc_valid) begin
                    slot_d  = alloc_slot;
                    base_d  = alloc_addr;
                    cnt_d   = 8'd0;
                    state_d = S_WRITE;
                end else if (tmo_q == TW'(ALLOC_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    code_d  = E_SPACE;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITE: begin
                // Handshake on the abort cycle is still written to BRAM
                if (abort) begin
                    err_d   = 1'b1;
                    code_d  = E_ABORT;
                    state_d = S_IDLE;
                end else if (hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == total_q - 8'd1) state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                res_d   = slot_q;
                state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            total_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            slot_q  <= '0;
            base_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
            res_q   <= 4'hF;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            slot_q  <= slot_d;
            base_q  <= base_d;
            err_q   <= err_d;
            code_q  <= code_d;
            res_q   <= res_d;
        end
    end

    assign elem_ready  = (state_q == S_WRITE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign error       = err_q;
    assign err_code    = code_q;
    assign result_slot = res_q;

    assign alloc_req   = (state_q == S_ALLOC);
    assign alloc_m     = m_q;
    assign alloc_n     = n_q;

    assign commit_req  = (state_q == S_COMMIT);
    assign commit_slot = slot_q;
    assign commit_m    = m_q;
    assign commit_n    = n_q;
    assign commit_addr = base_q;

    assign bram_we     = hs;
    assign bram_addr   = hs ? base_q + ADDR_WIDTH'(cnt_q) : '0;
    assign bram_din    = hs ? elem_data : '0;

endmodule

// File: doc/matrix_store_writer.md
Name:
matrix_store_writer

Overview:
Initiator side of the matrix directory's allocation/commit protocol. Accepts a dimension request plus a row-major element stream, requests a slot and BRAM region, writes elements to BRAM, then commits the slot metadata. Sits between the input/parse front-end and the matrix directory plus data BRAM; one matrix in flight at a time.

Parameters:
ELEMENT_WIDTH, 8, element data width
ADDR_WIDTH, 12, BRAM address width
MAX_DIM, 5, largest legal row/column count
ALLOC_TIMEOUT, 4, cycles to wait for alloc_valid before declaring no space

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a store; sampled only in IDLE
start_m  in  4  requested rows
start_n  in  4  requested columns
abort  in  1  cancel the in-flight store
elem_valid  in  1  element stream valid
elem_data  in  ELEMENT_WIDTH  element value, row-major order
elem_ready  out  1  writer accepts an element this cycle
busy  out  1  not IDLE
done  out  1  one-cycle pulse after a successful commit
error  out  1  one-cycle failure pulse
err_code  out  2  01 bad dims, 10 no space, 11 aborted; held until the next accepted start
result_slot  out  4  slot of the last successful store
alloc_req  out  1  allocation request, one cycle
alloc_m  out  4  latched rows
alloc_n  out  4  latched columns
alloc_valid  in  1  allocation granted
alloc_slot  in  4  granted slot
alloc_addr  in  ADDR_WIDTH  granted base address
commit_req  out  1  commit pulse, one cycle
commit_slot  out  4  granted slot
commit_m  out  4  rows
commit_n  out  4  columns
commit_addr  out  ADDR_WIDTH  granted base address
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_WIDTH  BRAM write address
bram_din  out  ELEMENT_WIDTH  BRAM write data

Behaviour:
- Reset: clk/rst_n as decided: reset rst_n, asynchronous, active-low; clock clk. State is IDLE. Every output is 0, except result_slot, which resets to 4'hF.
- States: IDLE, ALLOC, WAIT, WRITE, COMMIT, FINISH.
- IDLE: on start with 1 <= start_m, start_n <= MAX_DIM, latch m, n and total = m*n (8-bit), clear err_code, go to ALLOC. On start with any dimension that is 0 or greater than MAX_DIM, pulse error with err_code=01 and stay in IDLE.
- ALLOC: drive alloc_req=1 with alloc_m/alloc_n for exactly one cycle, then go to WAIT with the timeout counter at 0.
- WAIT: on alloc_valid=1, latch alloc_slot/alloc_addr, clear the element count, go to WRITE. If ALLOC_TIMEOUT cycles pass without alloc_valid, pulse error with 10 and return to IDLE. alloc_valid outside WAIT is ignored.
- WRITE: elem_ready=1. Each handshake (elem_valid & elem_ready) drives combinationally in the same cycle: bram_we=1, bram_addr = base + count (mod 2^ADDR_WIDTH), bram_din = elem_data; count then increments. The handshake with count == total-1 moves to COMMIT. Gaps in elem_valid stall the writer with no penalty.
- COMMIT: commit_req=1 for one cycle with the latched slot, m, n, base. Next state is FINISH.
- FINISH: done=1, result_slot = latched slot, then IDLE. busy is 0 the cycle after FINISH.
- abort in WAIT or WRITE: go to IDLE, pulse error with 11, issue no commit. Any in-progress handshake that cycle is still written. abort is ignored in IDLE, ALLOC, COMMIT and FINISH.
- start is ignored while busy. elem_ready is 0 outside WRITE.
- The directory derives the next free address from committed matrices, so no new alloc_req is issued until the previous commit has completed (guaranteed by one-in-flight).
- alloc_m, alloc_n and the commit_* fields hold their latched values between pulses. Consumers must qualify them with the request pulses.

Test Plan:
- start m=2,n=3; alloc_valid at the cycle after alloc_req with slot=1, addr=0x010; stream 6 elements 0xA0..0xA5 -> writes to 0x010..0x015 in order; commit_req with slot 1, m 2, n 3, addr 0x010; done pulse; result_slot=1.
- start m=0,n=3, then m=6,n=2 -> error pulse with err_code=01 each time; alloc_req never asserted; busy stays 0.
- start m=3,n=3 with alloc_valid held 0 -> error with 10 after ALLOC_TIMEOUT=4 cycles; no commit; IDLE.
- m=2,n=2 with elem_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes at consecutive addresses; commit only after the 4th.
- abort after 2 of 4 elements -> error with 11; no commit_req; a following start m=1,n=1 completes normally.
- start pulsed during WRITE with different dims -> ignored; commit carries the original dims.
